ripple_cnt_sched: RTL and testbench

RIPPLE_CNT_SCHED -- requirements
Module: ripple_cnt_sched

---
 rtl/ripple_cnt_sched.sv | 161 ++++++++++++++++
 tb/tb_ripple_cnt_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_cnt_sched.sv
// ripple_cnt_sched: arbitrates two delay requesters onto one shared external
// 4-bit ripple counter. The granted requester's length is run as a sequence
// of count ticks; after each tick the counter is given SETTLE cycles to ripple
// and is then compared against an internal shadow count. A mismatch or a
// withdrawn request aborts the transaction. All outputs are registered from
// the next-state decode so they line up with the state they belong to.
module ripple_cnt_sched #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic [3:0] cnt_q,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       err,
    output logic       busy,
    output logic       cnt_rst,
    output logic       cnt_tick
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        TICK,
        WAIT,
        DONE,
        ABORT
    } state_t;

    // Index of the last WAIT cycle; the counter is only trusted there.
    localparam logic [2:0] WAIT_LAST = 3'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] gnt_nxt;
    logic       mismatch;
    logic       withdrawn;
    logic [3:0] tgt;
    logic [3:0] sh;
    logic [2:0] wcnt;
    logic       ptr;    // 1 = requester 1 wins a tie, 0 = requester 0 wins

    // The granted requester dropping its level request ends the transaction.
    assign withdrawn = |(gnt & ~req);

    // Next-state and next-grant decode.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        mismatch  = 1'b0;
        case (state)
            IDLE: begin
                case (req)
                    2'b01:   gnt_nxt = 2'b01;
                    2'b10:   gnt_nxt = 2'b10;
                    2'b11:   gnt_nxt = ptr ? 2'b10 : 2'b01;
                    default: gnt_nxt = 2'b00;
                endcase
                if (|req) begin
                    state_nxt = CLR;
                end
            end
            CLR: begin
                if (withdrawn) begin
                    state_nxt = ABORT;
                end else if (tgt != 4'd0) begin
                    state_nxt = TICK;
                end else begin
                    state_nxt = DONE;
                end
            end
            TICK: begin
                state_nxt = withdrawn ? ABORT : WAIT;
            end
            WAIT: begin
                if (withdrawn) begin
                    state_nxt = ABORT;
                end else if (wcnt == WAIT_LAST) begin
                    if (cnt_q != sh) begin
                        state_nxt = ABORT;
                        mismatch  = 1'b1;
                    end else if (sh == tgt) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = TICK;
                    end
                end
            end
            DONE, ABORT: begin
                state_nxt = IDLE;
                gnt_nxt   = 2'b00;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 2'b00;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt      <= 2'b00;
            done     <= 2'b00;
            err      <= 1'b0;
            busy     <= 1'b0;
            cnt_tick <= 1'b0;
            cnt_rst  <= 1'b1;
        end else begin
            gnt      <= gnt_nxt;
            done     <= (state_nxt == DONE) ? gnt_nxt : 2'b00;
            err      <= mismatch;
            busy     <= (state_nxt != IDLE);
            cnt_tick <= (state_nxt == TICK);
            cnt_rst  <= (state_nxt == CLR) || (state_nxt == ABORT);
        end
    end

    // Target latch, shadow count and settle-wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt  <= 4'd0;
            sh   <= 4'd0;
            wcnt <= 3'd0;
        end else begin
            if ((state == IDLE) && (state_nxt == CLR)) begin
                tgt <= gnt_nxt[1] ? len1 : len0;
                sh  <= 4'd0;
            end else if (state == TICK) begin
                sh <= sh + 4'd1;
            end
            if (state == WAIT) begin
                wcnt <= wcnt + 3'd1;
            end else begin
                wcnt <= 3'd0;
            end
        end
    end

    // Round-robin pointer moves to the other requester when a grant ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if ((state == DONE) || (state == ABORT)) begin
            ptr <= ~gnt[1];
        end
    end

endmodule

// File: tb/tb_ripple_cnt_sched.sv
// Testbench for ripple_cnt_sched: directed transactions against a behavioural
// ripple counter; done/err pulses are checked by a scoreboard monitor.
module tb_ripple_cnt_sched;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [3:0] cnt_q;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       err;
    logic       busy;
    logic       cnt_rst;
    logic       cnt_tick;

    ripple_cnt_sched #(.SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .len0     (len0),
        .len1     (len1),
        .cnt_q    (cnt_q),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .cnt_rst  (cnt_rst),
        .cnt_tick (cnt_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External ripple counter: clocked by cnt_tick, cleared by cnt_rst.
    logic [3:0] model_q = 4'd0;
    logic       stuck   = 1'b0;
    always @(posedge cnt_tick or posedge cnt_rst) begin
        if (cnt_rst) model_q <= 4'd0;
        else         model_q <= model_q + 4'd1;
    end
    assign cnt_q = stuck ? 4'd0 : model_q;

    typedef struct {
        logic [1:0] done;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   tick_log[$];
    int   overlap = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", (n < 100), 1);
    endtask

    // Monitor: logs ticks and pops the scoreboard on every done/err pulse.
    always @(negedge clk) begin
        if (cnt_tick === 1'b1) tick_log.push_back(cyc);
        if (cnt_tick === 1'b1 && cnt_rst === 1'b1) overlap++;
        if (done !== 2'b00 || err !== 1'b0) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: done=%b err=%b at cycle %0d, expected no pulse",
                         done, err, cyc);
            end else begin
                e = sbq.pop_front();
                if (done !== e.done || err !== e.err || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL sb_pulse: done=%b err=%b cycle=%0d, expected done=%b err=%b cycle=%0d",
                             done, err, cyc, e.done, e.err, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        req  = 2'b00;
        len0 = 4'd0;
        len1 = 4'd0;
        #2;
        check("rst_gnt",      gnt,      0);
        check("rst_done",     done,     0);
        check("rst_err",      err,      0);
        check("rst_busy",     busy,     0);
        check("rst_cnt_tick", cnt_tick, 0);
        check("rst_cnt_rst",  cnt_rst,  1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("cnt_rst_release", cnt_rst, 0);

        // len0=3 on requester 0: ticks at c+2, c+5, c+8, done at c+11.
        len0 = 4'd3;
        tick_log.delete();
        req = 2'b01;
        c = cyc;
        sbq.push_back('{done: 2'b01, err: 1'b0, cyc: c + 11});
        @(negedge clk);
        check("a_gnt",     gnt,     2'b01);
        check("a_busy",    busy,    1);
        check("a_cnt_rst", cnt_rst, 1);
        repeat (10) @(negedge clk);
        req = 2'b00;
        check("a_ticks", tick_log.size(), 3);
        for (int i = 0; i < tick_log.size() && i < 3; i++)
            check("a_tick_cyc", tick_log[i], c + 2 + 3 * i);
        wait_idle();

        // len1=0 on requester 1: CLR then DONE, no ticks.
        len1 = 4'd0;
        tick_log.delete();
        req = 2'b10;
        c = cyc;
        sbq.push_back('{done: 2'b10, err: 1'b0, cyc: c + 2});
        @(negedge clk);
        check("b_gnt", gnt, 2'b10);
        @(negedge clk);
        req = 2'b00;
        check("b_ticks", tick_log.size(), 0);
        wait_idle();

        // Both requesting, len=1: grants alternate 01, 10, 01 with IDLE gaps.
        len0 = 4'd1;
        len1 = 4'd1;
        req = 2'b11;
        c = cyc;
        sbq.push_back('{done: 2'b01, err: 1'b0, cyc: c + 5});
        sbq.push_back('{done: 2'b10, err: 1'b0, cyc: c + 11});
        sbq.push_back('{done: 2'b01, err: 1'b0, cyc: c + 17});
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 1)  check("c_gnt1", gnt, 2'b01);
            if (k == 6)  check("c_gap1_gnt", gnt, 2'b00);
            if (k == 6)  check("c_gap1_busy", busy, 0);
            if (k == 7)  check("c_gnt2", gnt, 2'b10);
            if (k == 12) check("c_gap2_gnt", gnt, 2'b00);
            if (k == 13) check("c_gnt3", gnt, 2'b01);
            if (k == 17) req = 2'b00;
        end
        wait_idle();

        // Counter stuck at 0, len0=2: err in ABORT at c+5, then gnt clears.
        stuck = 1'b1;
        len0 = 4'd2;
        req = 2'b01;
        c = cyc;
        sbq.push_back('{done: 2'b00, err: 1'b1, cyc: c + 5});
        repeat (5) @(negedge clk);
        check("d_abort_cnt_rst", cnt_rst, 1);
        req = 2'b00;
        @(negedge clk);
        check("d_gnt_clear", gnt, 2'b00);
        check("d_busy", busy, 0);
        stuck = 1'b0;

        // Requester 1 short job: leaves the pointer favouring requester 0.
        len1 = 4'd0;
        req = 2'b10;
        c = cyc;
        sbq.push_back('{done: 2'b10, err: 1'b0, cyc: c + 2});
        repeat (2) @(negedge clk);
        req = 2'b00;
        wait_idle();

        // len0=4, req0 dropped in the second WAIT: silent ABORT.
        len0 = 4'd4;
        tick_log.delete();
        req = 2'b01;
        c = cyc;
        repeat (6) @(negedge clk);
        check("f_in_wait_tick", cnt_tick, 0);
        check("f_ticks", tick_log.size(), 2);
        req = 2'b00;
        @(negedge clk);
        check("f_abort_cnt_rst", cnt_rst, 1);
        check("f_abort_gnt", gnt, 2'b01);
        @(negedge clk);
        check("f_gnt_clear", gnt, 2'b00);
        check("f_busy", busy, 0);

        // Pointer advanced past requester 0: a tie now goes to requester 1.
        len0 = 4'd0;
        len1 = 4'd0;
        req = 2'b11;
        c = cyc;
        sbq.push_back('{done: 2'b10, err: 1'b0, cyc: c + 2});
        @(negedge clk);
        check("f_ptr_gnt", gnt, 2'b10);
        @(negedge clk);
        req = 2'b00;
        wait_idle();

        // len0=15 with len0 changed after grant: 15 ticks, done at c+47.
        len0 = 4'd15;
        tick_log.delete();
        req = 2'b01;
        c = cyc;
        @(negedge clk);
        len0 = 4'd1;
        sbq.push_back('{done: 2'b01, err: 1'b0, cyc: c + 47});
        repeat (46) @(negedge clk);
        req = 2'b00;
        check("g_ticks", tick_log.size(), 15);
        check("g_cnt_q", cnt_q, 4'd15);
        wait_idle();

        // Reset asserted during TICK: async return to reset values, no pulses.
        len0 = 4'd5;
        req = 2'b01;
        c = cyc;
        repeat (2) @(negedge clk);
        check("h_in_tick", cnt_tick, 1);
        #1 rst = 1'b1;
        #1;
        check("h_gnt",      gnt,      0);
        check("h_busy",     busy,     0);
        check("h_cnt_tick", cnt_tick, 0);
        check("h_cnt_rst",  cnt_rst,  1);
        check("h_done",     done,     0);
        check("h_err",      err,      0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("h_idle_after", busy, 0);

        // Pointer back at requester 0 after reset.
        len0 = 4'd0;
        len1 = 4'd0;
        req = 2'b11;
        c = cyc;
        sbq.push_back('{done: 2'b01, err: 1'b0, cyc: c + 2});
        @(negedge clk);
        check("h_ptr_gnt", gnt, 2'b01);
        @(negedge clk);
        req = 2'b00;
        wait_idle();
        repeat (3) @(negedge clk);

        check("tick_rst_overlap", overlap, 0);
        check("sb_leftover", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
